// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: MEM-stage handshake states, word-alignment helpers and width constants.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pipeline_pkg;

    localparam int         N_DEFAULT       = 32;
    localparam int         REG_ADDR_W      = 5;
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_e;

    // A word access must have both byte-offset bits clear.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/ff_en.sv
// Single-bit flop with synchronous enable and async active-high reset to 0.
// Latency: 1 cycle when en_i is high; holds otherwise.
// Backpressure: none; en_i low simply holds the stored bit.
// Ports: clk, rst, en_i (load enable), d_i (next value), q_o (stored value).
module ff_en (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= 1'b0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/mem_handshake_fsm.sv
// Data-memory req/ack handshake: IDLE/BUSY state, timeout counter, req/we/stall/err generation.
// Latency: an aligned op acked in its first cycle completes with zero wait; otherwise it waits in BUSY.
// Backpressure: stall_o freezes upstream until ack or timeout abort; stall drops in the abort cycle.
// Ports: clk, rst, mem_read_i, mem_write_i, addr_lsb_i[1:0], dmem_ack_i in;
//        dmem_req_o, dmem_we_o, mem_stall_o, mem_err_o out.
module mem_handshake_fsm
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read_i,
    input  logic       mem_write_i,
    input  logic [1:0] addr_lsb_i,
    input  logic       dmem_ack_i,
    output logic       dmem_req_o,
    output logic       dmem_we_o,
    output logic       mem_stall_o,
    output logic       mem_err_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mem_op;
    logic illegal;
    logic misaligned;
    logic aligned_op;
    logic timeout;

    assign mem_op     = mem_read_i ^ mem_write_i;
    assign illegal    = mem_read_i & mem_write_i;
    assign misaligned = mem_op & is_misaligned(addr_lsb_i);
    assign aligned_op = mem_op & ~misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dmem_req_o = 1'b0;
        timeout    = 1'b0;
        mem_err_o  = 1'b0;
        case (state_q)
            IDLE: begin
                // Counter sits at zero here so it is already cleared on entry to BUSY.
                cnt_d     = '0;
                mem_err_o = illegal | misaligned;
                if (aligned_op) begin
                    dmem_req_o = 1'b1;
                    if (!dmem_ack_i) begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                dmem_req_o = 1'b1;
                // Ack is tested first so a late ack in the last allowed cycle still completes.
                if (dmem_ack_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    timeout   = 1'b1;
                    mem_err_o = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign dmem_we_o = dmem_req_o & mem_write_i;
    // The abort cycle releases the pipeline so the failed op leaves as a bubble.
    assign mem_stall_o = dmem_req_o & ~dmem_ack_i & ~timeout;

endmodule

// File: rtl/registerNbit.sv
// N-bit register with synchronous enable and async active-high reset to 0.
// Latency: 1 cycle when en_i is high; holds otherwise.
// Backpressure: none; en_i low simply holds the stored word.
// Ports: clk, rst, en_i (load enable), d_i[N-1:0] (next value), q_o[N-1:0] (stored value).
module registerNbit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/stage4_mem_access.sv
// MEM stage: word load/store over a req/ack data bus, MEM/WB pipeline registers, stage-4 forwarding copies.
// Latency: load data appears on MemWb_ReadDataStage4 one edge after the ack cycle; forwarding is combinational.
// Backpressure: mem_stall freezes PC..EX/MEM while an access is outstanding; MEM/WB takes a bubble meanwhile.
// Ports in : clk, rst, ExMem_* stage-3 controls/data, dmem_ack, dmem_rdata.
// Ports out: dmem_req/we/addr/wdata, mem_stall, mem_err, ExMem_*Stage4 forwarding copies, MemWb_* registers.
module stage4_mem_access
    import pipeline_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ExMem_RegwriteStage3,
    input  logic                  ExMem_MemReadStage3,
    input  logic                  ExMem_MemWriteStage3,
    input  logic                  ExMem_MemtoRegStage3,
    input  logic [N-1:0]          ExMem_AluResult_Stage3,
    input  logic [N-1:0]          ExMem_ReadData2Bypass,
    input  logic [REG_ADDR_W-1:0] ExMem_RdAddStage3,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [N-1:0]          dmem_addr,
    output logic [N-1:0]          dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [N-1:0]          dmem_rdata,
    output logic                  mem_stall,
    output logic                  mem_err,
    output logic [N-1:0]          ExMem_AluResult_Stage4,
    output logic [REG_ADDR_W-1:0] ExMem_RdAddStage4,
    output logic                  ExMem_RegwriteStage4,
    output logic                  MemWb_RegwriteStage4,
    output logic                  MemWb_MemtoRegStage4,
    output logic [N-1:0]          MemWb_ReadDataStage4,
    output logic [N-1:0]          MemWb_AluResultStage4,
    output logic [REG_ADDR_W-1:0] MemWb_RdAddStage4
);

    logic memwb_en;
    logic regwrite_d;
    logic load_done;

    mem_handshake_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .mem_read_i  (ExMem_MemReadStage3),
        .mem_write_i (ExMem_MemWriteStage3),
        .addr_lsb_i  (ExMem_AluResult_Stage3[1:0]),
        .dmem_ack_i  (dmem_ack),
        .dmem_req_o  (dmem_req),
        .dmem_we_o   (dmem_we),
        .mem_stall_o (mem_stall),
        .mem_err_o   (mem_err)
    );

    assign dmem_addr  = ExMem_AluResult_Stage3;
    assign dmem_wdata = ExMem_ReadData2Bypass;

    assign ExMem_AluResult_Stage4 = ExMem_AluResult_Stage3;
    assign ExMem_RdAddStage4      = ExMem_RdAddStage3;
    assign ExMem_RegwriteStage4   = ExMem_RegwriteStage3;

    assign memwb_en = ~mem_stall;

    // RegWrite is reloaded every edge: a stall inserts a bubble, and any erroring op
    // (illegal, misaligned or timed out) must not write back.
    assign regwrite_d = ExMem_RegwriteStage3 & ~mem_stall & ~mem_err;

    // A completed load implies ack, so stall is already low in this cycle.
    assign load_done = dmem_req & dmem_ack & ExMem_MemReadStage3 & ~ExMem_MemWriteStage3;

    ff_en u_memwb_regwrite (
        .clk  (clk),
        .rst  (rst),
        .en_i (1'b1),
        .d_i  (regwrite_d),
        .q_o  (MemWb_RegwriteStage4)
    );

    ff_en u_memwb_memtoreg (
        .clk  (clk),
        .rst  (rst),
        .en_i (memwb_en),
        .d_i  (ExMem_MemtoRegStage3),
        .q_o  (MemWb_MemtoRegStage4)
    );

    registerNbit #(
        .N (N)
    ) u_memwb_aluresult (
        .clk  (clk),
        .rst  (rst),
        .en_i (memwb_en),
        .d_i  (ExMem_AluResult_Stage3),
        .q_o  (MemWb_AluResultStage4)
    );

    registerNbit #(
        .N (REG_ADDR_W)
    ) u_memwb_rdadd (
        .clk  (clk),
        .rst  (rst),
        .en_i (memwb_en),
        .d_i  (ExMem_RdAddStage3),
        .q_o  (MemWb_RdAddStage4)
    );

    // Load data only changes on a completed load; otherwise the last loaded word is kept.
    registerNbit #(
        .N (N)
    ) u_memwb_readdata (
        .clk  (clk),
        .rst  (rst),
        .en_i (load_done),
        .d_i  (dmem_rdata),
        .q_o  (MemWb_ReadDataStage4)
    );

endmodule

// File: tb/tb_stage4_mem_access.sv
// Directed bench for the MEM stage: reset, load with wait states, zero-wait store, misaligned/illegal ops,
// timeout abort and ack-at-timeout, reset mid-access, back-to-back ALU ops with forwarding.
// Inputs change 1ns after a rising edge; combinational outputs are sampled on the falling edge.
module tb_stage4_mem_access;

    logic        clk;
    logic        rst;
    logic        ExMem_RegwriteStage3;
    logic        ExMem_MemReadStage3;
    logic        ExMem_MemWriteStage3;
    logic        ExMem_MemtoRegStage3;
    logic [31:0] ExMem_AluResult_Stage3;
    logic [31:0] ExMem_ReadData2Bypass;
    logic [4:0]  ExMem_RdAddStage3;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        mem_err;
    logic [31:0] ExMem_AluResult_Stage4;
    logic [4:0]  ExMem_RdAddStage4;
    logic        ExMem_RegwriteStage4;
    logic        MemWb_RegwriteStage4;
    logic        MemWb_MemtoRegStage4;
    logic [31:0] MemWb_ReadDataStage4;
    logic [31:0] MemWb_AluResultStage4;
    logic [4:0]  MemWb_RdAddStage4;

    int vec_cnt;
    int miss_cnt;

    stage4_mem_access #(
        .N       (32),
        .TIMEOUT (16)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ExMem_RegwriteStage3   (ExMem_RegwriteStage3),
        .ExMem_MemReadStage3    (ExMem_MemReadStage3),
        .ExMem_MemWriteStage3   (ExMem_MemWriteStage3),
        .ExMem_MemtoRegStage3   (ExMem_MemtoRegStage3),
        .ExMem_AluResult_Stage3 (ExMem_AluResult_Stage3),
        .ExMem_ReadData2Bypass  (ExMem_ReadData2Bypass),
        .ExMem_RdAddStage3      (ExMem_RdAddStage3),
        .dmem_req               (dmem_req),
        .dmem_we                (dmem_we),
        .dmem_addr              (dmem_addr),
        .dmem_wdata             (dmem_wdata),
        .dmem_ack               (dmem_ack),
        .dmem_rdata             (dmem_rdata),
        .mem_stall              (mem_stall),
        .mem_err                (mem_err),
        .ExMem_AluResult_Stage4 (ExMem_AluResult_Stage4),
        .ExMem_RdAddStage4      (ExMem_RdAddStage4),
        .ExMem_RegwriteStage4   (ExMem_RegwriteStage4),
        .MemWb_RegwriteStage4   (MemWb_RegwriteStage4),
        .MemWb_MemtoRegStage4   (MemWb_MemtoRegStage4),
        .MemWb_ReadDataStage4   (MemWb_ReadDataStage4),
        .MemWb_AluResultStage4  (MemWb_AluResultStage4),
        .MemWb_RdAddStage4      (MemWb_RdAddStage4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rw, input logic rd_en, input logic wr_en, input logic m2r,
                         input logic [31:0] addr, input logic [31:0] wdat, input logic [4:0] rd);
        ExMem_RegwriteStage3   = rw;
        ExMem_MemReadStage3    = rd_en;
        ExMem_MemWriteStage3   = wr_en;
        ExMem_MemtoRegStage3   = m2r;
        ExMem_AluResult_Stage3 = addr;
        ExMem_ReadData2Bypass  = wdat;
        ExMem_RdAddStage3      = rd;
    endtask

    task automatic set_nop();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_nop();
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++; if (dmem_req !== 1'b0) begin miss_cnt++; $display("FAIL reset_req got %0h want 0", dmem_req); end
        vec_cnt++; if (mem_stall !== 1'b0) begin miss_cnt++; $display("FAIL reset_stall got %0h want 0", mem_stall); end
        vec_cnt++; if (mem_err !== 1'b0) begin miss_cnt++; $display("FAIL reset_err got %0h want 0", mem_err); end
        vec_cnt++; if (MemWb_RegwriteStage4 !== 1'b0) begin miss_cnt++; $display("FAIL reset_rw got %0h want 0", MemWb_RegwriteStage4); end
        vec_cnt++; if (MemWb_ReadDataStage4 !== 32'h0) begin miss_cnt++; $display("FAIL reset_rdata got %h want 0", MemWb_ReadDataStage4); end
        @(negedge clk);
        rst = 1'b0;
        next_edge();
    endtask

    task automatic test_load();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec_cnt++; if (mem_stall !== 1'b1) begin miss_cnt++; $display("FAIL load_stall[%0d] got %0h want 1", i, mem_stall); end
            vec_cnt++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin miss_cnt++; $display("FAIL load_req[%0d] got req=%0h we=%0h want req=1 we=0", i, dmem_req, dmem_we); end
            next_edge();
            vec_cnt++; if (MemWb_RegwriteStage4 !== 1'b0) begin miss_cnt++; $display("FAIL load_bubble[%0d] got %0h want 0", i, MemWb_RegwriteStage4); end
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        vec_cnt++; if (mem_stall !== 1'b0) begin miss_cnt++; $display("FAIL load_ack_stall got %0h want 0", mem_stall); end
        next_edge();
        set_nop();
        vec_cnt++; if (MemWb_ReadDataStage4 !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL load_rdata got %h want deadbeef", MemWb_ReadDataStage4); end
        vec_cnt++; if (MemWb_RdAddStage4 !== 5'd5) begin miss_cnt++; $display("FAIL load_rd got %0d want 5", MemWb_RdAddStage4); end
        vec_cnt++; if (MemWb_RegwriteStage4 !== 1'b1) begin miss_cnt++; $display("FAIL load_rw got %0h want 1", MemWb_RegwriteStage4); end
        vec_cnt++; if (MemWb_MemtoRegStage4 !== 1'b1) begin miss_cnt++; $display("FAIL load_m2r got %0h want 1", MemWb_MemtoRegStage4); end
        vec_cnt++; if (MemWb_AluResultStage4 !== 32'h100) begin miss_cnt++; $display("FAIL load_alu got %h want 100", MemWb_AluResultStage4); end
    endtask

    task automatic test_store();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h204, 32'h12345678, 5'd0);
        dmem_ack = 1'b1;
        @(negedge clk);
        vec_cnt++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin miss_cnt++; $display("FAIL store_req got req=%0h we=%0h want 1/1", dmem_req, dmem_we); end
        vec_cnt++; if (mem_stall !== 1'b0) begin miss_cnt++; $display("FAIL store_stall got %0h want 0", mem_stall); end
        vec_cnt++; if (dmem_addr !== 32'h204 || dmem_wdata !== 32'h12345678) begin miss_cnt++; $display("FAIL store_bus got addr=%h wdata=%h want 204/12345678", dmem_addr, dmem_wdata); end
        next_edge();
        set_nop();
        vec_cnt++; if (MemWb_RegwriteStage4 !== 1'b0) begin miss_cnt++; $display("FAIL store_rw got %0h want 0", MemWb_RegwriteStage4); end
        vec_cnt++; if (MemWb_AluResultStage4 !== 32'h204) begin miss_cnt++; $display("FAIL store_alu got %h want 204", MemWb_AluResultStage4); end
        vec_cnt++; if (MemWb_ReadDataStage4 !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL store_rdata_hold got %h want deadbeef", MemWb_ReadDataStage4); end
        @(negedge clk);
        vec_cnt++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin miss_cnt++; $display("FAIL store_idle got req=%0h stall=%0h want 0/0", dmem_req, mem_stall); end
        next_edge();
    endtask

    task automatic test_misaligned_illegal();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 5'd9);
        @(negedge clk);
        vec_cnt++; if (dmem_req !== 1'b0) begin miss_cnt++; $display("FAIL misal_req got %0h want 0", dmem_req); end
        vec_cnt++; if (mem_err !== 1'b1) begin miss_cnt++; $display("FAIL misal_err got %0h want 1", mem_err); end
        vec_cnt++; if (mem_stall !== 1'b0) begin miss_cnt++; $display("FAIL misal_stall got %0h want 0", mem_stall); end
        next_edge();
        vec_cnt++; if (MemWb_RegwriteStage4 !== 1'b0) begin miss_cnt++; $display("FAIL misal_rw got %0h want 0", MemWb_RegwriteStage4); end
        vec_cnt++; if (MemWb_RdAddStage4 !== 5'd9) begin miss_cnt++; $display("FAIL misal_rd got %0d want 9", MemWb_RdAddStage4); end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h108, 32'h0, 5'd3);
        @(negedge clk);
        vec_cnt++; if (mem_err !== 1'b1 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin miss_cnt++; $display("FAIL illegal_out got err=%0h req=%0h stall=%0h want 1/0/0", mem_err, dmem_req, mem_stall); end
        next_edge();
        set_nop();
        vec_cnt++; if (MemWb_RegwriteStage4 !== 1'b0) begin miss_cnt++; $display("FAIL illegal_rw got %0h want 0", MemWb_RegwriteStage4); end
        @(negedge clk);
        vec_cnt++; if (mem_err !== 1'b0) begin miss_cnt++; $display("FAIL err_clear got %0h want 0", mem_err); end
        next_edge();
    endtask

    task automatic test_timeout();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 5'd10);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            vec_cnt++; if (mem_stall !== 1'b1 || mem_err !== 1'b0) begin miss_cnt++; $display("FAIL to_wait[%0d] got stall=%0h err=%0h want 1/0", i, mem_stall, mem_err); end
            next_edge();
        end
        @(negedge clk);
        vec_cnt++; if (mem_stall !== 1'b0 || mem_err !== 1'b1) begin miss_cnt++; $display("FAIL to_abort got stall=%0h err=%0h want 0/1", mem_stall, mem_err); end
        next_edge();
        set_nop();
        vec_cnt++; if (MemWb_RegwriteStage4 !== 1'b0) begin miss_cnt++; $display("FAIL to_rw got %0h want 0", MemWb_RegwriteStage4); end
        vec_cnt++; if (MemWb_ReadDataStage4 !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL to_rdata_hold got %h want deadbeef", MemWb_ReadDataStage4); end
        vec_cnt++; if (MemWb_AluResultStage4 !== 32'h300) begin miss_cnt++; $display("FAIL to_alu got %h want 300", MemWb_AluResultStage4); end
        @(negedge clk);
        vec_cnt++; if (dmem_req !== 1'b0 || mem_err !== 1'b0) begin miss_cnt++; $display("FAIL to_idle got req=%0h err=%0h want 0/0", dmem_req, mem_err); end
        next_edge();

        // Same access, but the ack lands in the final allowed cycle.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h304, 32'h0, 5'd11);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            vec_cnt++; if (mem_stall !== 1'b1) begin miss_cnt++; $display("FAIL late_wait[%0d] got %0h want 1", i, mem_stall); end
            next_edge();
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        vec_cnt++; if (mem_err !== 1'b0 || mem_stall !== 1'b0) begin miss_cnt++; $display("FAIL late_ack got err=%0h stall=%0h want 0/0", mem_err, mem_stall); end
        next_edge();
        set_nop();
        vec_cnt++; if (MemWb_RegwriteStage4 !== 1'b1) begin miss_cnt++; $display("FAIL late_rw got %0h want 1", MemWb_RegwriteStage4); end
        vec_cnt++; if (MemWb_ReadDataStage4 !== 32'hCAFEF00D) begin miss_cnt++; $display("FAIL late_rdata got %h want cafef00d", MemWb_ReadDataStage4); end
        vec_cnt++; if (MemWb_RdAddStage4 !== 5'd11) begin miss_cnt++; $display("FAIL late_rd got %0d want 11", MemWb_RdAddStage4); end
    endtask

    task automatic test_reset_mid_access();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 5'd12);
        @(negedge clk);
        vec_cnt++; if (mem_stall !== 1'b1) begin miss_cnt++; $display("FAIL rst_pre_stall got %0h want 1", mem_stall); end
        next_edge();
        next_edge();
        // Second BUSY cycle: reset with the upstream registers clearing alongside.
        #1;
        rst = 1'b1;
        set_nop();
        #1;
        vec_cnt++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin miss_cnt++; $display("FAIL rst_mid_bus got req=%0h stall=%0h want 0/0", dmem_req, mem_stall); end
        vec_cnt++; if (MemWb_ReadDataStage4 !== 32'h0 || MemWb_RegwriteStage4 !== 1'b0) begin miss_cnt++; $display("FAIL rst_mid_memwb got rdata=%h rw=%0h want 0/0", MemWb_ReadDataStage4, MemWb_RegwriteStage4); end
        vec_cnt++; if (MemWb_AluResultStage4 !== 32'h0 || MemWb_RdAddStage4 !== 5'd0 || MemWb_MemtoRegStage4 !== 1'b0) begin miss_cnt++; $display("FAIL rst_mid_fields got alu=%h rd=%0d m2r=%0h want 0", MemWb_AluResultStage4, MemWb_RdAddStage4, MemWb_MemtoRegStage4); end
        @(negedge clk);
        rst = 1'b0;
        next_edge();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h104, 32'h0, 5'd7);
        @(negedge clk);
        vec_cnt++; if (mem_stall !== 1'b1) begin miss_cnt++; $display("FAIL post_rst_stall got %0h want 1", mem_stall); end
        next_edge();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0BADF00D;
        @(negedge clk);
        vec_cnt++; if (mem_stall !== 1'b0 || mem_err !== 1'b0) begin miss_cnt++; $display("FAIL post_rst_ack got stall=%0h err=%0h want 0/0", mem_stall, mem_err); end
        next_edge();
        set_nop();
        vec_cnt++; if (MemWb_ReadDataStage4 !== 32'h0BADF00D || MemWb_RdAddStage4 !== 5'd7 || MemWb_RegwriteStage4 !== 1'b1) begin miss_cnt++; $display("FAIL post_rst_load got rdata=%h rd=%0d rw=%0h want 0badf00d/7/1", MemWb_ReadDataStage4, MemWb_RdAddStage4, MemWb_RegwriteStage4); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 32'(i), 32'h0, 5'(i));
            @(negedge clk);
            vec_cnt++; if (ExMem_AluResult_Stage4 !== 32'(i) || ExMem_RdAddStage4 !== 5'(i) || ExMem_RegwriteStage4 !== 1'b1) begin miss_cnt++; $display("FAIL fwd[%0d] got alu=%h rd=%0d rw=%0h want %0d/%0d/1", i, ExMem_AluResult_Stage4, ExMem_RdAddStage4, ExMem_RegwriteStage4, i, i); end
            vec_cnt++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin miss_cnt++; $display("FAIL alu_bus[%0d] got req=%0h stall=%0h want 0/0", i, dmem_req, mem_stall); end
            if (i > 1) begin
                vec_cnt++; if (MemWb_AluResultStage4 !== 32'(i - 1)) begin miss_cnt++; $display("FAIL b2b_alu[%0d] got %h want %0d", i, MemWb_AluResultStage4, i - 1); end
            end
            next_edge();
        end
        set_nop();
        vec_cnt++; if (MemWb_AluResultStage4 !== 32'd3 || MemWb_RdAddStage4 !== 5'd3 || MemWb_RegwriteStage4 !== 1'b1) begin miss_cnt++; $display("FAIL b2b_last got alu=%h rd=%0d rw=%0h want 3/3/1", MemWb_AluResultStage4, MemWb_RdAddStage4, MemWb_RegwriteStage4); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1);
    end

    initial begin
        vec_cnt  = 0;
        miss_cnt = 0;
        test_reset();
        test_load();
        test_store();
        test_misaligned_illegal();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
